serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub_pkg.sv | 25 ++
 rtl/serial_sub_fsub_cell.sv | 21 ++
 rtl/serial_sub.sv | 147 ++++++++++++++
 tb/tb_serial_sub.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared definitions for the bit-serial subtractor: FSM state
//               encoding and the bit-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    // FSM state encoding, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int c_max_width = 32;

    // The counter must be able to hold every value 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_sub_fsub_cell.sv
`default_nettype none
// ============================================================================
// Module      : fsub_cell
// Description : One-bit full subtractor, x - y - z.
// Ports       : x (minuend bit), y (subtrahend bit), z (borrow in)
//               -> d (difference bit), b (borrow out)
// Revision    : 1.0 - initial release
// ============================================================================
module fsub_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d,
    output logic b
);

    assign d = x ^ y ^ z;
    assign b = (~x & y) | (~x & z) | (y & z);

endmodule
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub
// Description : Bit-serial subtractor computing a - b - bin, LSB first, one
//               bit per clock. Produces borrow-out and signed overflow.
// Ports       : clk, rst (sync, active-high)
//               start, a[WIDTH], b[WIDTH], bin   - request and operands
//               busy, done (1-cycle pulse)       - status
//               diff[WIDTH], bout, ovf           - held result
// Timing      : start sampled in IDLE; WIDTH RUN cycles; one DONE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int              c_cw   = cnt_width(WIDTH);
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    state_t           r_state;
    state_t           w_state_next;

    // r_a doubles as the result register: each RUN step consumes its LSB and
    // the difference bit is shifted into the MSB that the shift just vacated,
    // so after WIDTH steps it holds the complete difference.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [c_cw-1:0]  r_cnt;
    logic             r_amsb;
    logic             r_bmsb;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic             w_d;
    logic             w_b;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    fsub_cell u_cell (
        .x (r_a[0]),
        .y (r_b[0]),
        .z (r_borrow),
        .d (w_d),
        .b (w_b)
    );

    assign w_last = (r_cnt == c_last);

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_d;
        end else begin : g_res_wn
            assign w_res_next = {w_d, r_a[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_amsb   <= 1'b0;
            r_bmsb   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                        // Operand sign bits are shifted away during RUN, so
                        // keep them for the overflow decision.
                        r_amsb   <= a[WIDTH-1];
                        r_bmsb   <= b[WIDTH-1];
                    end
                end
                ST_RUN: begin
                    r_a      <= w_res_next;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_b;
                    r_cnt    <= r_cnt + c_one;
                    if (w_last) begin
                        // The final difference bit w_d is the result MSB.
                        r_diff <= w_res_next;
                        r_bout <= w_b;
                        r_ovf  <= (r_amsb != r_bmsb) && (w_d != r_amsb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub
// Description : Directed self-checking bench for serial_sub (WIDTH=8 and
//               WIDTH=1 instances sharing clock and reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8, ovf8;
    logic [7:0] diff8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       bin1 = 1'b0;
    logic       busy1, done1, bout1, ovf1;
    logic [0:0] diff1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
    );

    // Hand-computed vectors: a, b, bin -> diff, bout, ovf
    logic [7:0] t_a    [0:5] = '{8'h05, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'hA5};
    logic [7:0] t_b    [0:5] = '{8'h03, 8'h01, 8'hFF, 8'h01, 8'hFF, 8'h5A};
    logic       t_bin  [0:5] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
    logic [7:0] t_diff [0:5] = '{8'h02, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h4A};
    logic       t_bout [0:5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
    logic       t_ovf  [0:5] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};

    // Full-subtractor truth table indexed by {a,b,bin}: {D,B}
    logic [1:0] t1_db [0:7] = '{2'b00, 2'b11, 2'b11, 2'b01,
                                2'b10, 2'b00, 2'b00, 2'b11};

    // Raise start just after an edge, then count edges until done is seen.
    // lat = -1 when done never arrives within the budget.
    task automatic op8(input logic [7:0] a_i, input logic [7:0] b_i,
                       input logic bin_i, output int lat, output int stamp);
        @(posedge clk); #1;
        start8 = 1'b1; a8 = a_i; b8 = b_i; bin8 = bin_i;
        lat = -1; stamp = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start8 = 1'b0;
            if (done8) begin
                lat = n; stamp = cyc;
                break;
            end
        end
    endtask

    task automatic op1(input logic a_i, input logic b_i, input logic bin_i,
                       output int lat);
        @(posedge clk); #1;
        start1 = 1'b1; a1 = a_i; b1 = b_i; bin1 = bin_i;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            if (done1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total += 5;
        if (busy8 !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", busy8); end
        if (done8 !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b want=0", done8); end
        if (diff8 !== 8'h00) begin bad++; $display("FAIL reset_diff got=%h want=00", diff8); end
        if (bout8 !== 1'b0)  begin bad++; $display("FAIL reset_bout got=%b want=0", bout8); end
        if (ovf8 !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf8); end
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        int lat, stamp;
        for (int i = 0; i < 6; i++) begin
            op8(t_a[i], t_b[i], t_bin[i], lat, stamp);
            total += 4;
            if (lat != 9) begin bad++; $display("FAIL vec%0d_latency got=%0d want=9", i, lat); end
            if (diff8 !== t_diff[i]) begin bad++; $display("FAIL vec%0d_diff got=%h want=%h", i, diff8, t_diff[i]); end
            if (bout8 !== t_bout[i]) begin bad++; $display("FAIL vec%0d_bout got=%b want=%b", i, bout8, t_bout[i]); end
            if (ovf8 !== t_ovf[i])   begin bad++; $display("FAIL vec%0d_ovf got=%b want=%b", i, ovf8, t_ovf[i]); end
            // done is a single-cycle pulse, then back to IDLE with held result
            @(posedge clk); #1;
            total += 3;
            if (done8 !== 1'b0) begin bad++; $display("FAIL vec%0d_pulse got=%b want=0", i, done8); end
            if (busy8 !== 1'b0) begin bad++; $display("FAIL vec%0d_idle got=%b want=0", i, busy8); end
            if (diff8 !== t_diff[i]) begin bad++; $display("FAIL vec%0d_hold got=%h want=%h", i, diff8, t_diff[i]); end
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        int first = -1;
        logic [7:0] fdiff = '0;
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            // Start pulses sampled in RUN cycles 3 and 5 with new operands
            start8 = (n == 2 || n == 4);
            a8 = 8'hAA; b8 = 8'h11; bin8 = 1'b1;
            if (done8) begin
                dones++;
                if (first < 0) begin first = n; fdiff = diff8; end
            end
        end
        start8 = 1'b0;
        total += 4;
        if (dones != 1)      begin bad++; $display("FAIL ign_done_count got=%0d want=1", dones); end
        if (first != 9)      begin bad++; $display("FAIL ign_latency got=%0d want=9", first); end
        if (fdiff !== 8'h02) begin bad++; $display("FAIL ign_diff got=%h want=02", fdiff); end
        if (diff8 !== 8'h02) begin bad++; $display("FAIL ign_diff_hold got=%h want=02", diff8); end
    endtask

    task automatic test_abort();
        int lat, stamp;
        int dones = 0;
        op8(8'h80, 8'h01, 1'b0, lat, stamp);   // leave a non-zero result
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
            start8 = 1'b0;
        end
        rst = 1'b1;                              // sampled in the 4th RUN cycle
        @(posedge clk); #1;
        rst = 1'b0;
        total += 5;
        if (busy8 !== 1'b0)  begin bad++; $display("FAIL abort_busy got=%b want=0", busy8); end
        if (done8 !== 1'b0)  begin bad++; $display("FAIL abort_done got=%b want=0", done8); end
        if (diff8 !== 8'h00) begin bad++; $display("FAIL abort_diff got=%h want=00", diff8); end
        if (bout8 !== 1'b0)  begin bad++; $display("FAIL abort_bout got=%b want=0", bout8); end
        if (ovf8 !== 1'b0)   begin bad++; $display("FAIL abort_ovf got=%b want=0", ovf8); end
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (done8) dones++;
        end
        total += 1;
        if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
        op8(8'h10, 8'h01, 1'b0, lat, stamp);
        total += 3;
        if (lat != 9)        begin bad++; $display("FAIL abort_restart_lat got=%0d want=9", lat); end
        if (diff8 !== 8'h0F) begin bad++; $display("FAIL abort_restart_diff got=%h want=0F", diff8); end
        if (bout8 !== 1'b0)  begin bad++; $display("FAIL abort_restart_bout got=%b want=0", bout8); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, s1, s2;
        op8(8'h33, 8'h44, 1'b0, lat1, s1);     // 0x33-0x44 = 0xEF, borrow
        op8(8'h44, 8'h33, 1'b1, lat2, s2);     // start in the cycle after DONE
        total += 5;
        if (lat1 != 9)       begin bad++; $display("FAIL b2b_lat1 got=%0d want=9", lat1); end
        if (lat2 != 9)       begin bad++; $display("FAIL b2b_lat2 got=%0d want=9", lat2); end
        if (s2 - s1 != 10)   begin bad++; $display("FAIL b2b_period got=%0d want=10", s2 - s1); end
        if (diff8 !== 8'h10) begin bad++; $display("FAIL b2b_diff got=%h want=10", diff8); end
        if (bout8 !== 1'b0)  begin bad++; $display("FAIL b2b_bout got=%b want=0", bout8); end
    endtask

    task automatic test_width1();
        int lat;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            op1(v[2], v[1], v[0], lat);
            total += 3;
            if (lat != 2) begin bad++; $display("FAIL w1_%0d_latency got=%0d want=2", i, lat); end
            if (diff1[0] !== t1_db[i][1]) begin bad++; $display("FAIL w1_%0d_d got=%b want=%b", i, diff1[0], t1_db[i][1]); end
            if (bout1 !== t1_db[i][0])    begin bad++; $display("FAIL w1_%0d_b got=%b want=%b", i, bout1, t1_db[i][0]); end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_width1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
